// File: rtl/guitar_pkg.sv
// Shared screen geometry, sprite constants and the note slot record for the
// guitar-game video path.
package guitar_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int SPRITE_DIM = 64;

  localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

  // One falling note: y is the signed top row, negative while above the screen.
  typedef struct packed {
    logic               valid;
    logic signed [10:0] y;
  } note_slot_t;

endpackage

// File: rtl/note_slot_bank.sv
// Slot array for one fret lane: spawn allocation, per-frame scrolling,
// expiry off the screen bottom and the miss pulse.
module note_slot_bank
  import guitar_pkg::*;
#(
  parameter int NUM_NOTES = 4
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         frame_start,
  input  logic [2:0]                   speed,
  input  logic                         spawn,
  output logic                         spawn_ready,
  output logic                         miss_pulse,
  output note_slot_t [NUM_NOTES-1:0]   slots_o
);

  localparam logic signed [10:0] SPAWN_Y  = -(11'(SPRITE_DIM));
  localparam logic signed [10:0] EXPIRE_Y = 11'(SCREEN_H);

  note_slot_t [NUM_NOTES-1:0] slots_q, slots_d;
  logic                       miss_q, miss_d;
  logic signed [10:0]         adv_y [NUM_NOTES];
  logic                       free_found;

  always_comb begin
    for (int i = 0; i < NUM_NOTES; i++) begin
      adv_y[i] = slots_q[i].y + $signed({8'b0, speed});
    end
  end

  // NOTE: every variable gets its default before any branch, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    slots_d    = slots_q;
    miss_d     = 1'b0;
    free_found = 1'b0;

    if (frame_start) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        if (slots_q[i].valid) begin
          if (adv_y[i] >= EXPIRE_Y) begin
            slots_d[i].valid = 1'b0;
            miss_d           = 1'b1;
          end else begin
            slots_d[i].y = adv_y[i];
          end
        end
      end
    end

    // Allocation looks at pre-edge state, so a slot freed by this frame's
    // advance cannot be taken by a spawn in the same cycle.
    for (int i = 0; i < NUM_NOTES; i++) begin
      if (!free_found && !slots_q[i].valid) begin
        free_found = 1'b1;
        if (spawn) begin
          slots_d[i] = '{valid: 1'b1, y: SPAWN_Y};
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering. The slot array is a small
  // register file and must be reset so stale notes never render.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      slots_q <= '0;
      miss_q  <= 1'b0;
    end else begin
      slots_q <= slots_d;
      miss_q  <= miss_d;
    end
  end

  assign spawn_ready = free_found;
  assign miss_pulse  = miss_q;
  assign slots_o     = slots_q;

endmodule

// File: rtl/note_lane_renderer.sv
// One fret lane of falling notes: hit test against the slot bank, sprite RAM
// addressing and alignment of the returned colour with its pixel.
module note_lane_renderer
  import guitar_pkg::*;
#(
  parameter int         NUM_NOTES = 4,
  parameter logic [9:0] LANE_X    = 10'd288
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_start,
  input  logic [2:0]  speed,
  input  logic        spawn,
  output logic        spawn_ready,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [12:0] read_address,
  input  logic [23:0] rom_data,
  output logic        pixel_on,
  output logic [23:0] pixel_rgb,
  output logic        miss_pulse
);

  note_slot_t [NUM_NOTES-1:0] slots;

  note_slot_bank #(
    .NUM_NOTES (NUM_NOTES)
  ) u_bank (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .speed       (speed),
    .spawn       (spawn),
    .spawn_ready (spawn_ready),
    .miss_pulse  (miss_pulse),
    .slots_o     (slots)
  );

  logic signed [10:0]   dx;
  logic signed [10:0]   dy [NUM_NOTES];
  logic [NUM_NOTES-1:0] slot_hit;
  logic                 hit;
  logic [5:0]           hit_dy;

  // 0 <= d < 64 is equivalent to the upper five bits of the signed offset
  // being zero.
  always_comb begin
    dx = $signed({1'b0, DrawX}) - $signed({1'b0, LANE_X});
    for (int i = 0; i < NUM_NOTES; i++) begin
      dy[i]       = $signed({1'b0, DrawY}) - slots[i].y;
      slot_hit[i] = slots[i].valid && (dx[10:6] == 5'd0) && (dy[i][10:6] == 5'd0);
    end
  end

  // Scan from the top index down so the lowest-index hit is written last.
  always_comb begin
    hit    = 1'b0;
    hit_dy = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (slot_hit[i]) begin
        hit    = 1'b1;
        hit_dy = dy[i][5:0];
      end
    end
  end

  logic [12:0] addr_q, addr_d;
  logic        hit_d1_q, hit_d2_q;
  logic        pixel_on_q, pixel_on_d;
  logic [23:0] pixel_rgb_q, pixel_rgb_d;

  always_comb begin
    addr_d      = hit ? {1'b0, hit_dy, dx[5:0]} : 13'd0;
    pixel_on_d  = hit_d2_q && (rom_data != KEY_COLOR);
    pixel_rgb_d = pixel_on_d ? rom_data : 24'h000000;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_q      <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      pixel_on_q  <= 1'b0;
      pixel_rgb_q <= '0;
    end else begin
      addr_q      <= addr_d;
      hit_d1_q    <= hit;
      hit_d2_q    <= hit_d1_q;
      pixel_on_q  <= pixel_on_d;
      pixel_rgb_q <= pixel_rgb_d;
    end
  end

  assign read_address = addr_q;
  assign pixel_on     = pixel_on_q;
  assign pixel_rgb    = pixel_rgb_q;

endmodule
